// File: rtl/ff_arb_pkg.sv
// Shared constants for the video RAM arbiter: requester indices, FSM state
// encoding and the widths of the optional statistics counters.
package ff_arb_pkg;

  // Requester indices, also used as the grant identifier and for rr_last.
  localparam logic [1:0] REQ_VID = 2'd0;
  localparam logic [1:0] REQ_CPU = 2'd1;
  localparam logic [1:0] REQ_LDR = 2'd2;

  // Sequencer states: IDLE arbitrates, ACCESS is the RAM address cycle,
  // DATA is the cycle in which the RAM read data is valid.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DATA   = 2'd2
  } state_t;

  localparam int STAT_CNT_W  = 16;
  localparam int STAT_WAIT_W = 8;

endpackage

// File: rtl/ff_arb_stats.sv
// Grant statistics for ff_vram_arb: saturating per-requester grant counters
// and the saturating worst-case cpu wait (cycles from cpu_req rise to grant).
// Only instantiated when FF_VRAM_ARB_STATS_EN is defined.
module ff_arb_stats
  import ff_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_grant,
  input  logic [1:0]             i_gnt_idx,
  input  logic                   i_cpu_req,
  output logic [STAT_CNT_W-1:0]  o_vid_cnt,
  output logic [STAT_CNT_W-1:0]  o_cpu_cnt,
  output logic [STAT_CNT_W-1:0]  o_ldr_cnt,
  output logic [STAT_WAIT_W-1:0] o_cpu_maxwait
);

  logic [STAT_CNT_W-1:0]  r_vid_cnt, r_cpu_cnt, r_ldr_cnt;
  logic [STAT_WAIT_W-1:0] r_cpu_maxwait, r_cpu_wait;
  logic                   r_cpu_req_d, r_cpu_pend;
  logic                   w_cpu_rise, w_cpu_gnt;
  logic [STAT_WAIT_W-1:0] w_cur_wait;

  assign w_cpu_rise = i_cpu_req & ~r_cpu_req_d;
  assign w_cpu_gnt  = i_grant & (i_gnt_idx == REQ_CPU);
  // A request that rises on the grant edge itself has waited zero cycles.
  assign w_cur_wait = w_cpu_rise ? '0 : r_cpu_wait;

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vid_cnt <= '0;
      r_cpu_cnt <= '0;
      r_ldr_cnt <= '0;
    end else if (i_grant) begin
      if (i_gnt_idx == REQ_VID && r_vid_cnt != '1) r_vid_cnt <= r_vid_cnt + 1'b1;
      if (i_gnt_idx == REQ_CPU && r_cpu_cnt != '1) r_cpu_cnt <= r_cpu_cnt + 1'b1;
      if (i_gnt_idx == REQ_LDR && r_ldr_cnt != '1) r_ldr_cnt <= r_ldr_cnt + 1'b1;
    end
  end

  // Track the open cpu wait and fold it into the maximum on the cpu grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cpu_req_d   <= 1'b0;
      r_cpu_pend    <= 1'b0;
      r_cpu_wait    <= '0;
      r_cpu_maxwait <= '0;
    end else begin
      r_cpu_req_d <= i_cpu_req;
      if (w_cpu_gnt) begin
        r_cpu_pend <= 1'b0;
        r_cpu_wait <= '0;
        if (w_cur_wait > r_cpu_maxwait) r_cpu_maxwait <= w_cur_wait;
      end else if (w_cpu_rise || r_cpu_pend) begin
        r_cpu_pend <= 1'b1;
        if (w_cur_wait != '1) r_cpu_wait <= w_cur_wait + 1'b1;
        else                  r_cpu_wait <= w_cur_wait;
      end
    end
  end

  assign o_vid_cnt     = r_vid_cnt;
  assign o_cpu_cnt     = r_cpu_cnt;
  assign o_ldr_cnt     = r_ldr_cnt;
  assign o_cpu_maxwait = r_cpu_maxwait;

endmodule

// File: rtl/ff_vram_arb.sv
// ff_vram_arb: shares one single-port synchronous video RAM between the video
// fetch (fixed highest priority), the game CPU and the debug/ROM loader
// (round-robin between cpu and ldr). Each access takes IDLE -> ACCESS -> DATA,
// so a request granted at edge N has its ack high in the cycle after edge N+2.
// Optional statistics outputs are enabled with `define FF_VRAM_ARB_STATS_EN.
//
// Handshake: a requester raises req with stable addr/we/wdata and holds them
// until its one-cycle ack; rdata is valid while ack is high (reads only, a
// write leaves rdata unchanged). A requester whose ack is high is not eligible
// in that cycle, so a still-held req is never served twice for one request.
module ff_vram_arb
  import ff_arb_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
`ifdef FF_VRAM_ARB_STATS_EN
  output logic [15:0]   stat_vid_cnt,
  output logic [15:0]   stat_cpu_cnt,
  output logic [15:0]   stat_ldr_cnt,
  output logic [7:0]    stat_cpu_maxwait,
`endif
  output logic [1:0]    o_dbg_state
);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_rr_last, r_gnt_idx, w_gnt_idx;
  logic          r_gnt_we;
  logic          w_grant_fire, w_ack_fire;
  logic          w_elig_vid, w_elig_cpu, w_elig_ldr;
  logic [AW-1:0] w_sel_addr;
  logic          w_sel_we;
  logic [DW-1:0] w_sel_wdata;

  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [DW-1:0] r_ram_wdata;
  logic          r_vid_ack, r_cpu_ack, r_ldr_ack;
  logic [DW-1:0] r_vid_rdata, r_cpu_rdata, r_ldr_rdata;

  // Mask requesters whose ack is high this cycle.
  assign w_elig_vid = vid_req & ~r_vid_ack;
  assign w_elig_cpu = cpu_req & ~r_cpu_ack;
  assign w_elig_ldr = ldr_req & ~r_ldr_ack;

  // Next-state, grant decision and ack strobe.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_fire = 1'b0;
    w_ack_fire   = 1'b0;
    w_gnt_idx    = REQ_VID;
    case (r_state)
      IDLE: begin
        if (w_elig_vid || w_elig_cpu || w_elig_ldr) begin
          w_grant_fire = 1'b1;
          w_state_nxt  = ACCESS;
          if (w_elig_vid)                    w_gnt_idx = REQ_VID;
          else if (w_elig_cpu && w_elig_ldr) w_gnt_idx = (r_rr_last == REQ_CPU) ? REQ_LDR : REQ_CPU;
          else if (w_elig_cpu)               w_gnt_idx = REQ_CPU;
          else                               w_gnt_idx = REQ_LDR;
        end
      end
      ACCESS:  w_state_nxt = DATA;
      DATA: begin
        w_state_nxt = IDLE;
        w_ack_fire  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request field mux for the winning requester; video is read-only.
  always_comb begin
    w_sel_addr  = vid_addr;
    w_sel_we    = 1'b0;
    w_sel_wdata = '0;
    case (w_gnt_idx)
      REQ_CPU: begin
        w_sel_addr  = cpu_addr;
        w_sel_we    = cpu_we;
        w_sel_wdata = cpu_wdata;
      end
      REQ_LDR: begin
        w_sel_addr  = ldr_addr;
        w_sel_we    = ldr_we;
        w_sel_wdata = ldr_wdata;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // RAM port registers, grant bookkeeping, acks and returned read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_rr_last   <= REQ_LDR;
      r_gnt_idx   <= REQ_VID;
      r_gnt_we    <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_vid_rdata <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else begin
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_ldr_ack <= 1'b0;
      if (w_grant_fire) begin
        r_ram_addr  <= w_sel_addr;
        r_ram_we    <= w_sel_we;
        r_ram_wdata <= w_sel_wdata;
        r_gnt_idx   <= w_gnt_idx;
        r_gnt_we    <= w_sel_we;
        if (w_gnt_idx != REQ_VID) r_rr_last <= w_gnt_idx;
      end
      // The RAM has sampled the write during ACCESS; never leave we high.
      if (r_state == ACCESS) r_ram_we <= 1'b0;
      if (w_ack_fire) begin
        case (r_gnt_idx)
          REQ_CPU: begin
            r_cpu_ack <= 1'b1;
            if (!r_gnt_we) r_cpu_rdata <= ram_rdata;
          end
          REQ_LDR: begin
            r_ldr_ack <= 1'b1;
            if (!r_gnt_we) r_ldr_rdata <= ram_rdata;
          end
          default: begin
            r_vid_ack   <= 1'b1;
            r_vid_rdata <= ram_rdata;
          end
        endcase
      end
    end
  end

  assign vid_ack     = r_vid_ack;
  assign vid_rdata   = r_vid_rdata;
  assign cpu_ack     = r_cpu_ack;
  assign cpu_rdata   = r_cpu_rdata;
  assign ldr_ack     = r_ldr_ack;
  assign ldr_rdata   = r_ldr_rdata;
  assign ram_addr    = r_ram_addr;
  assign ram_we      = r_ram_we;
  assign ram_wdata   = r_ram_wdata;
  assign o_dbg_state = r_state;

`ifdef FF_VRAM_ARB_STATS_EN
  ff_arb_stats u_stats (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_grant       (w_grant_fire),
    .i_gnt_idx     (w_gnt_idx),
    .i_cpu_req     (cpu_req),
    .o_vid_cnt     (stat_vid_cnt),
    .o_cpu_cnt     (stat_cpu_cnt),
    .o_ldr_cnt     (stat_ldr_cnt),
    .o_cpu_maxwait (stat_cpu_maxwait)
  );
`endif

endmodule

// File: doc/ff_vram_arb.md
Name: ff_vram_arb

Overview:
- Arbiter and sequencer sharing one single-port synchronous video RAM between three requesters:
  - video refresh fetch (vid), which feeds the VGA scan path;
  - game CPU (cpu);
  - debug/ROM loader port (ldr).
- Sits between the video pipeline, CPU bus glue and the RAM primitive inside the FPGA top.
- Serialises accesses, returns read data with an ack, and guarantees video fetch priority so the display never tears.

Parameters:
- AW, 14, RAM address width.
- DW, 16, RAM data width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- vid_req  in  1  video read request; held until vid_ack.
- vid_addr  in  AW  video read address.
- vid_ack  out  1  one-cycle pulse; vid_rdata valid in the same cycle.
- vid_rdata  out  DW  video read data.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  CPU read data, valid while cpu_ack is high.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: same widths and rules as the cpu_* ports.
- ram_addr  out  AW  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DW  registered RAM write data.
- ram_rdata  in  DW  RAM read data, valid one cycle after the address cycle.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n.
- Reset values: all acks 0, ram_we 0, ram_addr 0, ram_wdata 0, all *_rdata 0, state IDLE, rr_last = LDR (so CPU wins the first tie).
- FSM states and transitions:
  - IDLE: sample requests. If any eligible request is present, latch the grant and its addr/we/wdata into the ram_* registers, then go to ACCESS.
  - ACCESS: RAM samples ram_addr/ram_we. Next edge: clear ram_we to 0, go to DATA.
  - DATA: ram_rdata is valid. Next edge: copy ram_rdata into the granted requester's rdata (read only; on a write, rdata holds its old value), pulse that requester's ack for 1 cycle, go to IDLE.
- Latency: request seen at edge N gives ack high in cycle N+3. Peak throughput is one access per 3 cycles.
- Priority:
  - vid is fixed highest priority.
  - cpu and ldr alternate round-robin: on a tie, grant the one not equal to rr_last.
  - rr_last updates only on cpu/ldr grants.
- Eligibility: a requester whose ack is high in the current cycle is masked for that cycle, so a held req is not double-served.
- Requester rules:
  - Requester inputs must stay stable from req rise until ack.
  - The arbiter samples addr/we/wdata only at the grant edge.
  - Dropping req before ack is illegal. The access still completes and the ack still pulses.
- Simultaneous events:
  - All three requesting: vid is granted.
  - cpu+ldr requesting: round-robin decides.
  - A req rising in ACCESS/DATA waits for IDLE.
- Worst-case wait: a cpu or ldr request waits at most two further video accesses plus one peer access, provided vid re-requests no faster than every 4 cycles.
- Reset mid-operation: return to IDLE immediately with ram_we = 0. The in-flight transaction is dropped with no ack; the requester re-issues it.

Optional Feature:
- Macro: FF_VRAM_ARB_STATS_EN.
- When defined, adds these outputs:
  - stat_vid_cnt, stat_cpu_cnt, stat_ldr_cnt: 16 bits each, saturating grant counters.
  - stat_cpu_maxwait: 8 bits, saturating maximum number of cycles from cpu_req rise to cpu grant.
  - All reset to 0 and are cleared by reset_n only.
- When not defined, these ports and their logic are absent. Arbitration timing is identical either way.

Decomposition:
- Package ff_arb_pkg holds:
  - requester index constants REQ_VID = 0, REQ_CPU = 1, REQ_LDR = 2;
  - FSM state encodings IDLE = 2'd0, ACCESS = 2'd1, DATA = 2'd2.
- Sub-module ff_arb_stats contains the counters and max-wait tracker. It is instantiated only under FF_VRAM_ARB_STATS_EN.

Test Plan:
- Reset, then a single cpu read of 0x0123 with RAM preloaded 0xBEEF: cpu_ack high exactly 3 cycles after the req edge, cpu_rdata = 0xBEEF, ram_we low throughout.
- ldr write 0x5A5A to 0x0010, then cpu read of 0x0010: RAM holds 0x5A5A, cpu_rdata = 0x5A5A, ldr_rdata unchanged (0).
- vid, cpu and ldr all asserted at the same edge: grant order vid, cpu, ldr; acks in cycles N+3, N+6, N+9.
- cpu and ldr held continuously for 6 accesses: grants alternate cpu, ldr, cpu, ldr, cpu, ldr; no ack is ever high in two consecutive cycles for the same port.
- reset_n low during DATA of a cpu read: no cpu_ack; ram_we = 0 on the next cycle; a re-issued request completes normally with 3-cycle latency.
- With FF_VRAM_ARB_STATS_EN: 70000 vid grants gives stat_vid_cnt = 0xFFFF; cpu blocked behind 2 vid accesses gives stat_cpu_maxwait = 6.
